usb_tx_serializer: RTL
======================

USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have parameter SYNC_BITS, default 8, number of SYNC bits (SYNC_BITS-1 zeros then one '1').
REQ-002 SHALL have ports:
- clk12_i  in  1  12 MHz bit clock, the only clock.
- rstn_i  in  1  asynchronous, active-low reset.
- txReqSend_i  in  1  start a packet; sampled in IDLE only.
- txData_i  in  8  byte to send, LSB first.
- txDataValid_i  in  1  txData_i valid.
- txIsLastByte_i  in  1  qualifies txData_i as final packet byte.
- txAcceptNewData_o  out  1  byte accepted this cycle, when txDataValid_i && txAcceptNewData_o.
- bitStuffReady_i  in  1  downstream bit stuffer consumes dataBit_o this cycle.
- dataBit_o  out  1  serial bit to the bit stuffer.
- dataValid_o  out  1  dataBit_o meaningful (SYNC/DATA).
- sendSE0_o  out  1  request SE0 line state (EOP).
- txBusy_o  out  1  state != IDLE.
- txDone_o  out  1  one-cycle pulse, packet finished.
- txUnderrun_o  out  1  one-cycle pulse, byte missing mid-packet.

Function
REQ-003 SHALL implement states IDLE, SYNC, DATA, EOP_WAIT, EOP_SE0, EOP_J.
REQ-004 IDLE: outputs low, dataBit_o=1 (J-idle); on txReqSend_i -> SYNC next cycle, bit counter = 0.
REQ-005 SYNC: dataBit_o = (cnt == SYNC_BITS-1); cnt advances only when bitStuffReady_i=1; after last SYNC bit consumed -> DATA.
REQ-006 SHALL hold a shift register (8b + 3b bit index) plus a one-entry holding register with valid flag and last flag.
REQ-007 txAcceptNewData_o SHALL be high in SYNC and DATA whenever the holding register is empty, and in the same cycle it is being emptied; a byte SHALL be accepted at most once per cycle.
REQ-008 DATA: dataBit_o = shift[0]; on bitStuffReady_i=1 shift right, index+1; on index 7 consumed, load holding register into shift (zero-cycle gap, no idle bit).
REQ-009 bitStuffReady_i=0 SHALL freeze shift register, index and counters; dataBit_o held stable.
REQ-010 Bit 7 of a byte flagged last consumed -> EOP_WAIT; no further bytes accepted until IDLE.
REQ-011 Bit 7 consumed, holding register empty, current byte not last -> txUnderrun_o pulse, -> EOP_WAIT.
REQ-012 DATA entered with holding register empty (no byte during SYNC) SHALL be treated as underrun per REQ-011.
REQ-013 EOP_WAIT: dataValid_o=0; stays while bitStuffReady_i=0 (pending stuffed zero), else -> EOP_SE0.
REQ-014 EOP_SE0: sendSE0_o=1 for exactly 2 cycles (2-bit counter), then -> EOP_J.
REQ-015 EOP_J: sendSE0_o=0, dataBit_o=1 for 1 cycle, txDone_o=1 that cycle, -> IDLE.
REQ-016 txReqSend_i outside IDLE SHALL be ignored; txDataValid_i in IDLE SHALL not be accepted.
REQ-017 dataValid_o SHALL be 1 exactly in SYNC and DATA.
REQ-018 Latency: first SYNC bit on dataBit_o 1 cycle after txReqSend_i sampled.

Reset
REQ-019 rstn_i low SHALL asynchronously force IDLE, clear shift/holding/valid/counters; outputs: dataBit_o=1, all others 0.
REQ-020 Reset mid-packet SHALL abort without txDone_o/txUnderrun_o pulse; first cycle after release is IDLE.

Verification
REQ-021 Single byte 0xA5 last, bitStuffReady_i=1: dataBit_o = 0000000 1 then 1,0,1,0,0,1,0,1; 2 cycles sendSE0_o; 1 J cycle with txDone_o; 20 cycles req-to-done.
REQ-022 Bytes 0x01,0x80(last) back-to-back: 16 contiguous data bits, no gap, txAcceptNewData_o handshakes exactly twice.
REQ-023 0xFF last with stub stuffer (ready low every 7th cycle): each frozen cycle repeats dataBit_o; EOP_WAIT holds 1 cycle for trailing stuffed zero before SE0.
REQ-024 Two bytes non-last, third withheld: txUnderrun_o pulses once after bit 7 of byte 2, EOP follows, txDone_o pulses, no third accept.
REQ-025 rstn_i asserted during DATA bit 3: all outputs reset values immediately (asynchronous), no done/underrun pulse; new txReqSend_i then yields correct SYNC.
REQ-026 txReqSend_i held high through whole packet: exactly one packet sent, second starts only if still high in IDLE after EOP_J.

Source files
------------

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB full-speed packet serializer: SYNC, LSB-first data bytes, EOP
module usb_tx_serializer #(
  parameter int SYNC_BITS = 8
) (
  input  logic       clk12_i,
  input  logic       rstn_i,
  input  logic       txReqSend_i,
  input  logic [7:0] txData_i,
  input  logic       txDataValid_i,
  input  logic       txIsLastByte_i,
  output logic       txAcceptNewData_o,
  input  logic       bitStuffReady_i,
  output logic       dataBit_o,
  output logic       dataValid_o,
  output logic       sendSE0_o,
  output logic       txBusy_o,
  output logic       txDone_o,
  output logic       txUnderrun_o
);

  localparam int CW = (SYNC_BITS > 1) ? $clog2(SYNC_BITS) : 1;
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_EOP_WAIT, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;
  logic          r_shift_last;
  logic [7:0]    r_hold;
  logic          r_hold_valid;
  logic          r_hold_last;
  logic          r_got_last;
  logic [1:0]    r_se0_cnt;
  logic          r_underrun;

  logic w_sync_last;
  logic w_byte_end;
  logic w_need_byte;
  logic w_accept_win;
  logic w_accept;
  logic w_load_hold;
  logic w_load_bypass;
  logic w_underrun;

  // A new byte is needed when the last SYNC bit or bit 7 of a non-final byte is consumed.
  // If the holding register is empty, a byte accepted in that same cycle bypasses it
  // straight into the shift register so the bit stream has no gap.
  assign w_sync_last   = (r_state == S_SYNC) && bitStuffReady_i && (r_cnt == SYNC_LAST);
  assign w_byte_end    = (r_state == S_DATA) && bitStuffReady_i && (r_idx == 3'd7);
  assign w_need_byte   = w_sync_last || (w_byte_end && !r_shift_last);
  assign w_accept_win  = ((r_state == S_SYNC) || (r_state == S_DATA)) && !r_got_last &&
                         (!r_hold_valid || w_need_byte);
  assign w_accept      = w_accept_win && txDataValid_i;
  assign w_load_hold   = w_need_byte && r_hold_valid;
  assign w_load_bypass = w_need_byte && !r_hold_valid && w_accept;
  assign w_underrun    = w_need_byte && !r_hold_valid && !w_accept;

  assign txAcceptNewData_o = w_accept_win;
  assign txBusy_o          = (r_state != S_IDLE);
  assign txUnderrun_o      = r_underrun;

  // State register.
  always_ff @(posedge clk12_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode and line outputs; the line idles at J (dataBit_o=1) outside SYNC/DATA.
  always_comb begin
    w_next      = r_state;
    dataBit_o   = 1'b1;
    dataValid_o = 1'b0;
    sendSE0_o   = 1'b0;
    txDone_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (txReqSend_i) w_next = S_SYNC;
      end
      S_SYNC: begin
        dataValid_o = 1'b1;
        dataBit_o   = (r_cnt == SYNC_LAST);
        if (w_sync_last) w_next = w_underrun ? S_EOP_WAIT : S_DATA;
      end
      S_DATA: begin
        dataValid_o = 1'b1;
        dataBit_o   = r_shift[0];
        if (w_byte_end && (r_shift_last || w_underrun)) w_next = S_EOP_WAIT;
      end
      S_EOP_WAIT: begin
        if (bitStuffReady_i) w_next = S_EOP_SE0;
      end
      S_EOP_SE0: begin
        sendSE0_o = 1'b1;
        if (r_se0_cnt == 2'd1) w_next = S_EOP_J;
      end
      S_EOP_J: begin
        txDone_o = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: SYNC counter, shift register, holding register and EOP timer.
  always_ff @(posedge clk12_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt        <= '0;
      r_shift      <= 8'h00;
      r_idx        <= 3'd0;
      r_shift_last <= 1'b0;
      r_hold       <= 8'h00;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_got_last   <= 1'b0;
      r_se0_cnt    <= 2'd0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= w_underrun;
      r_se0_cnt  <= (r_state == S_EOP_SE0) ? r_se0_cnt + 2'd1 : 2'd0;
      if (r_state == S_IDLE) begin
        r_cnt        <= '0;
        r_idx        <= 3'd0;
        r_shift_last <= 1'b0;
        r_hold_valid <= 1'b0;
        r_hold_last  <= 1'b0;
        r_got_last   <= 1'b0;
      end else begin
        if ((r_state == S_SYNC) && bitStuffReady_i && (r_cnt != SYNC_LAST))
          r_cnt <= r_cnt + CW'(1);
        if (w_load_hold) begin
          r_shift      <= r_hold;
          r_shift_last <= r_hold_last;
          r_idx        <= 3'd0;
        end else if (w_load_bypass) begin
          r_shift      <= txData_i;
          r_shift_last <= txIsLastByte_i;
          r_idx        <= 3'd0;
        end else if ((r_state == S_DATA) && bitStuffReady_i) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_idx   <= r_idx + 3'd1;
        end
        if (w_accept && !w_load_bypass) begin
          r_hold       <= txData_i;
          r_hold_valid <= 1'b1;
          r_hold_last  <= txIsLastByte_i;
        end else if (w_load_hold) begin
          r_hold_valid <= 1'b0;
        end
        if (w_accept && txIsLastByte_i) r_got_last <= 1'b1;
      end
    end
  end

endmodule
